// File: rtl/shell_pkg.sv
// shell_pkg: serializer state encoding and ASCII constants for the shell transmitter
package shell_pkg;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    LF_START,
    LF_DATA,
    LF_STOP
  } tx_state_t;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
endpackage

// File: rtl/shell_tx_fifo.sv
// shell_tx_fifo: first-word-fall-through FIFO with occupancy count
module shell_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign dout = mem[rp];
  assign full = count == CNTW'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + CNTW'(push) - CNTW'(pop);
    end
  end
endmodule

// File: rtl/shell_tx.sv
// shell_tx: FIFO-buffered 8N1 UART transmitter with optional CR->CRLF expansion
module shell_tx
  import shell_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH = 16,
  parameter int CRLF_EXPAND = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [7:0]               i_TX_Byte,
  input  logic                     i_TX_DV,
  output logic                     o_TX_Ready,
  output logic                     UART_TX,
  output logic                     o_TX_Active,
  output logic                     o_TX_Done,
  output logic [$clog2(DEPTH):0]   o_FIFO_Count
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CMAX = CW'(CLKS_PER_BIT - 1);
  tx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n, head;
  logic full, empty, push, pop, bit_end;
  assign o_TX_Ready = !full && !RST;
  assign push = i_TX_DV && o_TX_Ready;
  assign bit_end = cnt == CMAX;
  shell_tx_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk(CLK),
    .rst(RST),
    .push(push),
    .pop(pop),
    .din(i_TX_Byte),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(o_FIFO_Count)
  );
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    idx_n = idx;
    sh_n = sh;
    pop = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!empty) begin
          pop = 1'b1;
          sh_n = head;
          state_n = START;
        end
      end
      START, LF_START: begin
        if (bit_end) begin
          cnt_n = '0;
          idx_n = '0;
          state_n = state == START ? DATA : LF_DATA;
        end
      end
      DATA, LF_DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          idx_n = idx + 1'b1;
          if (idx == 3'd7) state_n = state == DATA ? STOP : LF_STOP;
        end
      end
      STOP, LF_STOP: begin
        if (bit_end) begin
          cnt_n = '0;
          // the inserted LF reuses the shift register; the FIFO head stays put
          if (CRLF_EXPAND != 0 && state == STOP && sh == CR) begin
            sh_n = LF;
            state_n = LF_START;
          end else if (!empty) begin
            pop = 1'b1;
            sh_n = head;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      UART_TX <= 1'b1;
      o_TX_Active <= 1'b0;
      o_TX_Done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      UART_TX <= (state == START || state == LF_START) ? 1'b0 :
                 (state == DATA || state == LF_DATA) ? sh[idx] : 1'b1;
      o_TX_Active <= state != IDLE;
      o_TX_Done <= (state == STOP || state == LF_STOP) && bit_end;
    end
  end
endmodule

// File: tb/tb_shell_tx.sv
// tb_shell_tx: randomized scoreboard bench with a frame-level reference model and line receiver
module tb_shell_tx;
  localparam int CPB = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * CPB;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [7:0] i_TX_Byte = '0;
  logic i_TX_DV = 1'b0;
  logic o_TX_Ready, UART_TX, o_TX_Active, o_TX_Done;
  logic [$clog2(DEPTH):0] o_FIFO_Count;

  shell_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH), .CRLF_EXPAND(1)) dut (
    .CLK(CLK),
    .RST(RST),
    .i_TX_Byte(i_TX_Byte),
    .i_TX_DV(i_TX_DV),
    .o_TX_Ready(o_TX_Ready),
    .UART_TX(UART_TX),
    .o_TX_Active(o_TX_Active),
    .o_TX_Done(o_TX_Done),
    .o_FIFO_Count(o_FIFO_Count)
  );

  always #5 CLK = ~CLK;

  // reference model: byte queue plus "cycles left in current frame"
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  int rem = 0;
  int r_prev;
  bit lf_pend = 0;
  bit armed = 0;
  bit accept;
  logic [7:0] cur = '0;
  logic m_line = 1'b1, m_active = 1'b0, m_done = 1'b0;

  function automatic logic line_of(logic [7:0] b, int elapsed);
    int n;
    n = elapsed / CPB;
    return n == 0 ? 1'b0 : n <= 8 ? b[n-1] : 1'b1;
  endfunction

  always @(posedge CLK) begin
    armed = 1;
    if (RST) begin
      mq.delete();
      exp_q.delete();
      rem = 0;
      lf_pend = 0;
      m_line = 1'b1;
      m_active = 1'b0;
      m_done = 1'b0;
    end else begin
      r_prev = rem;
      m_active = r_prev > 0;
      m_line = r_prev == 0 ? 1'b1 : line_of(cur, FRAME - r_prev);
      m_done = r_prev == 1;
      accept = i_TX_DV && mq.size() < DEPTH;
      if (r_prev > 0) rem = r_prev - 1;
      if (r_prev <= 1) begin
        if (r_prev == 1 && lf_pend) begin
          cur = LF;
          lf_pend = 0;
          rem = FRAME;
        end else if (mq.size() > 0) begin
          cur = mq.pop_front();
          lf_pend = cur == CR;
          rem = FRAME;
        end
      end
      if (accept) begin
        mq.push_back(i_TX_Byte);
        exp_q.push_back(i_TX_Byte);
        if (i_TX_Byte == CR) exp_q.push_back(LF);
      end
    end
  end

  // monitor: per-cycle output checks and a serial receiver feeding the scoreboard
  int n_cmp = 0, n_bad = 0;
  bit fin = 0;
  bit rx_busy = 0;
  int rx_off = 0;
  logic [7:0] rx_b = '0;
  logic [7:0] want;

  task automatic chk(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  always @(negedge CLK) begin
    if (fin) begin
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end else if (armed) begin
      chk("tx_line", int'(UART_TX), int'(m_line));
      chk("tx_active", int'(o_TX_Active), int'(m_active));
      chk("tx_done", int'(o_TX_Done), int'(m_done));
      chk("tx_ready", int'(o_TX_Ready), int'(!RST && mq.size() < DEPTH));
      chk("fifo_count", int'(o_FIFO_Count), mq.size());
      if (RST) begin
        rx_busy = 0;
      end else if (!rx_busy && UART_TX == 1'b0) begin
        rx_busy = 1;
        rx_off = 0;
      end else if (rx_busy) begin
        rx_off++;
        if (rx_off % CPB == 2 && rx_off / CPB >= 1 && rx_off / CPB <= 8)
          rx_b[rx_off/CPB-1] = UART_TX;
        if (rx_off == 9 * CPB + 2) begin
          rx_busy = 0;
          chk("rx_stop_bit", int'(UART_TX), 1);
          if (exp_q.size() == 0) begin
            chk("rx_unexpected_byte", int'(rx_b), -1);
          end else begin
            want = exp_q.pop_front();
            chk("rx_byte", int'(rx_b), int'(want));
          end
        end
      end
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send(logic [7:0] b);
    i_TX_Byte = b;
    i_TX_DV = 1'b1;
    cyc();
    i_TX_DV = 1'b0;
  endtask

  initial begin
    cyc(3);
    RST = 1'b0;
    cyc(2);
    send(8'h67);
    cyc(50);
    send(CR);
    cyc(90);
    i_TX_DV = 1'b1;
    for (int i = 0; i < 18; i++) begin
      i_TX_Byte = 8'(i);
      cyc();
    end
    i_TX_DV = 1'b0;
    cyc(19 * FRAME);
    for (int i = 0; i < 3; i++) send(8'hA0 + 8'(i));
    cyc(3 * FRAME + 10);
    send(8'h55);
    send(8'hA1);
    send(8'hB2);
    cyc(15);
    RST = 1'b1;
    i_TX_DV = 1'b1;
    i_TX_Byte = 8'h77;
    cyc();
    RST = 1'b0;
    i_TX_DV = 1'b0;
    cyc(60);
    for (int i = 0; i < 2500; i++) begin
      i_TX_DV = $urandom_range(0, 2) == 0;
      i_TX_Byte = $urandom_range(0, 7) == 0 ? CR : 8'($urandom);
      RST = $urandom_range(0, 999) == 0;
      cyc();
    end
    RST = 1'b0;
    i_TX_DV = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (mq.size() == 0 && rem == 0 && !rx_busy) break;
      cyc();
    end
    cyc(2);
    fin = 1;
  end
endmodule
